// File: rtl/program_loader.sv
`timescale 1ns/1ps
// program_loader: turns a length-prefixed byte stream into instruction memory writes.
// Each word is packed from three bytes as {b0[3:0], b1, b2}; the CPU is held until the load ends.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
    parameter int unsigned INST_W     = 20,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] loaded_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [3:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_POST_LOAD = S_CHK;
`else
    localparam state_t S_POST_LOAD = S_DONE;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   n_q;
    logic [3:0]         b0_q;
    logic [7:0]         b1_q;
    logic [ADDR_W-1:0]  index_q;
    logic [CNT_W-1:0]   n_cand;
    logic               fire;
    logic               restart;
    logic               last_word;
    logic               in_ready_d;
    logic               imem_we_d;
    logic               cpu_hold_d;
    logic               done_d;
    logic               error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    assign fire         = in_valid && in_ready;
    assign restart      = start && ((state_q == S_DONE) || (state_q == S_ERR));
    assign n_cand       = {n_q[15:8], in_data};
    assign last_word    = ((32'(index_q) + 32'd1) == 32'(n_q));
    assign loaded_count = index_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CNT_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advances only on an accepted byte, except the single write cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CNT_HI: if (fire) state_d = S_CNT_LO;
            S_CNT_LO: begin
                if (fire) begin
                    if (n_cand == '0)                       state_d = S_POST_LOAD;
                    else if (32'(n_cand) > IMEM_DEPTH)      state_d = S_ERR;
                    else                                    state_d = S_B0;
                end
            end
            S_B0: begin
                if (fire) begin
                    if (in_data[7:4] != 4'd0) state_d = S_ERR;
                    else                      state_d = S_B1;
                end
            end
            S_B1:    if (fire) state_d = S_B2;
            S_B2:    if (fire) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_POST_LOAD : S_B0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (fire) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  if (start) state_d = S_CNT_HI;
            S_ERR:   if (start) state_d = S_CNT_HI;
            default: state_d = S_CNT_HI;
        endcase
    end

    // Output decode from the upcoming state so every output lands in a register aligned with it.
    always_comb begin
        in_ready_d = 1'b0;
        imem_we_d  = 1'b0;
        cpu_hold_d = 1'b1;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_d)
            S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2: in_ready_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK:   in_ready_d = 1'b1;
`endif
            S_WRITE: imem_we_d = 1'b1;
            S_DONE: begin
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
            end
            S_ERR:   error_d = 1'b1;
            default: in_ready_d = 1'b0;
        endcase
    end

    // Registered outputs; address and data are captured together with the b2 byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            in_ready <= in_ready_d;
            imem_we  <= imem_we_d;
            cpu_hold <= cpu_hold_d;
            done     <= done_d;
            error    <= error_d;
            if (imem_we_d) begin
                imem_addr  <= index_q;
                imem_wdata <= INST_W'({b0_q, b1_q, in_data});
            end
        end
    end

    // Length, partial word and word index bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            n_q     <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            index_q <= '0;
        end else begin
            case (state_q)
                S_CNT_HI: if (fire) n_q[15:8] <= in_data;
                S_CNT_LO: if (fire) n_q[7:0]  <= in_data;
                S_B0:     if (fire) b0_q      <= in_data[3:0];
                S_B1:     if (fire) b1_q      <= in_data;
                S_WRITE:  index_q <= index_q + ADDR_W'(1);
                default:  index_q <= index_q;
            endcase
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR of every payload byte, checked against the trailing byte.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            csum_q <= '0;
        end else if (fire && ((state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2))) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// Testbench for program_loader: directed image scenarios plus randomized images,
// checked every cycle against a byte-position based reference model.
module tb_program_loader;

    localparam int unsigned INST_W     = 20;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned IMEM_DEPTH = 256;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] loaded_count;

    program_loader #(.INST_W(INST_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(IMEM_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;
    int t_first  = 0;
    int t_end    = 0;
    int          w_addr[$];
    logic [19:0] w_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // status: 0 loading, 1 done, 2 error. pos counts accepted bytes of the current image.
    bit          m_ready, m_we, m_hold, m_done, m_err, m_chk;
    int          m_addr, m_count, m_n, pos, status;
    logic [19:0] m_wdata;
    logic [7:0]  m_b0, m_b1, m_csum;

    task automatic go_done();
        status = 1; m_done = 1; m_hold = 0; m_ready = 0;
    endtask

    task automatic go_err();
        status = 2; m_err = 1; m_hold = 1; m_ready = 0;
    endtask

    task automatic finish_image();
        if (CS != 0) begin
            m_chk = 1; m_ready = 1;
        end else begin
            go_done();
        end
    endtask

    task automatic take(input logic [7:0] b);
        int k;
        if (m_chk) begin
            if (b == m_csum) go_done(); else go_err();
        end else if (pos == 0) begin
            m_n = int'(b) << 8; pos = 1;
        end else if (pos == 1) begin
            m_n = m_n | int'(b); pos = 2;
            if (m_n == 0) finish_image();
            else if (m_n > int'(IMEM_DEPTH)) go_err();
        end else begin
            k = (pos - 2) % 3;
            m_csum = m_csum ^ b;
            if (k == 0) begin
                if (b[7:4] != 4'd0) go_err(); else m_b0 = b;
            end else if (k == 1) begin
                m_b1 = b;
            end else begin
                m_we = 1; m_ready = 0;
                m_addr = (pos - 2) / 3;
                m_wdata = {m_b0[3:0], m_b1, b};
            end
            pos++;
        end
    endtask

    always @(posedge clk) begin
        bit was_ready, was_we;
        cyc++;
        was_ready = m_ready;
        was_we    = m_we;
        m_we      = 0;
        if (rst) begin
            status = 0; pos = 0; m_n = 0; m_count = 0; m_addr = 0; m_wdata = '0;
            m_ready = 0; m_hold = 1; m_done = 0; m_err = 0; m_chk = 0; m_csum = '0;
        end else if (status != 0) begin
            if (start) begin
                status = 0; pos = 0; m_count = 0; m_chk = 0; m_csum = '0;
                m_ready = 1; m_hold = 1; m_done = 0; m_err = 0;
            end
        end else if (was_we) begin
            m_count++;
            if (m_count == m_n) finish_image(); else m_ready = 1;
        end else if (was_ready && in_valid) begin
            take(in_data);
        end else if (!was_ready) begin
            m_ready = 1;
        end
    end

    // Per-cycle comparison against the model, plus a log of observed writes.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("imem_we", 32'(imem_we), 32'(m_we));
            check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
            check("done", 32'(done), 32'(m_done));
            check("error", 32'(error), 32'(m_err));
            check("loaded_count", 32'(loaded_count), 32'(m_count));
            if (m_we) begin
                check("imem_addr", 32'(imem_addr), 32'(m_addr));
                check("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
            end
            if (imem_we === 1'b1) begin
                w_addr.push_back(int'(imem_addr));
                w_data.push_back(imem_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] bytes[$], input int stall_at, input int stall_len,
                        input int rnd_pct);
        foreach (bytes[i]) begin
            int waited = 0;
            bit acc = 0;
            while (!acc) begin
                @(negedge clk);
                if (done || error) begin
                    in_valid = 0; start = 0;
                    return;
                end
                in_valid = 1;
                if (i == stall_at && waited < stall_len) in_valid = 0;
                else if (rnd_pct > 0 && int'($urandom_range(99)) < rnd_pct) in_valid = 0;
                in_data = in_valid ? bytes[i] : 8'($urandom);
                start = (rnd_pct > 0 && $urandom_range(19) == 0);
                acc = in_valid && in_ready;
                if (acc && i == 0) t_first = cyc;
                waited++;
                if (waited > 100) begin
                    check("byte_accept_timeout", 32'(waited), 32'd100);
                    in_valid = 0; start = 0;
                    return;
                end
            end
        end
        @(negedge clk);
        in_valid = 0; start = 0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error)) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                check("completion_timeout", 32'(n), 32'd50);
                return;
            end
        end
        t_end = cyc;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        w_addr.delete(); w_data.delete();
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] q[$]);
        logic [7:0] x = '0;
        for (int i = 2; i < q.size(); i++) x = x ^ q[i];
        return x;
    endfunction

    task automatic add_csum(inout logic [7:0] q[$], input bit good);
        logic [7:0] c;
        c = csum_of(q);
        if (CS != 0) q.push_back(good ? c : (c ^ 8'h01));
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_loaded_count", 32'(loaded_count), 32'd0);
    endtask

    initial begin
        logic [7:0] img[$];
        @(posedge clk);
        cmp_en = 1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Two-word image, no backpressure.
        img = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC, 8'hDE};
        add_csum(img, 1);
        send(img, -1, 0, 0);
        wait_end();
        check("t1_writes", 32'(w_addr.size()), 32'd2);
        if (w_addr.size() == 2) begin
            check("t1_addr0", 32'(w_addr[0]), 32'd0);
            check("t1_data0", 32'(w_data[0]), 32'h12345);
            check("t1_addr1", 32'(w_addr[1]), 32'd1);
            check("t1_data1", 32'(w_data[1]), 32'hABCDE);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_count", 32'(loaded_count), 32'd2);
        check("t1_latency", 32'(t_end - t_first), 32'(10 + CS));

        // Same image with a 5-cycle stall before the 45 byte.
        pulse_start();
        send(img, 4, 5, 0);
        wait_end();
        check("t2_writes", 32'(w_addr.size()), 32'd2);
        if (w_addr.size() == 2) begin
            check("t2_data0", 32'(w_data[0]), 32'h12345);
            check("t2_data1", 32'(w_data[1]), 32'hABCDE);
        end
        check("t2_latency", 32'(t_end - t_first), 32'(15 + CS));

        // Framing error on b0.
        pulse_start();
        img = '{8'h00, 8'h03, 8'h1F, 8'h00, 8'h00};
        send(img, -1, 0, 0);
        wait_end();
        check("t3_error", 32'(error), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        check("t3_writes", 32'(w_addr.size()), 32'd0);
        check("t3_err_latency", 32'(t_end - t_first), 32'd3);

        // Empty image.
        pulse_start();
        img = '{8'h00, 8'h00};
        add_csum(img, 1);
        send(img, -1, 0, 0);
        wait_end();
        check("t4_done", 32'(done), 32'd1);
        check("t4_writes", 32'(w_addr.size()), 32'd0);

        // Length beyond memory depth.
        pulse_start();
        img = '{8'h01, 8'h01};
        send(img, -1, 0, 0);
        wait_end();
        check("t5_error", 32'(error), 32'd1);
        check("t5_writes", 32'(w_addr.size()), 32'd0);
        check("t5_err_latency", 32'(t_end - t_first), 32'd2);

        // Reset after one and a half words, then a fresh one-word image.
        pulse_start();
        img = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0A, 8'hBC};
        send(img, -1, 0, 0);
        check("t6_partial_writes", 32'(w_addr.size()), 32'd1);
        rst = 1;
        @(negedge clk);
        check_reset_values();
        rst = 0;
        w_addr.delete(); w_data.delete();
        img = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h07};
        add_csum(img, 1);
        send(img, -1, 0, 0);
        wait_end();
        check("t6_writes", 32'(w_addr.size()), 32'd1);
        if (w_addr.size() == 1) begin
            check("t6_addr0", 32'(w_addr[0]), 32'd0);
            check("t6_data0", 32'(w_data[0]), 32'h00007);
        end
        check("t6_done", 32'(done), 32'd1);

        if (CS != 0) begin
            pulse_start();
            img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
            send(img, -1, 0, 0);
            wait_end();
            check("cs_good_done", 32'(done), 32'd1);
            pulse_start();
            img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
            send(img, -1, 0, 0);
            wait_end();
            check("cs_bad_error", 32'(error), 32'd1);
            check("cs_bad_count", 32'(loaded_count), 32'd1);
            check("cs_bad_data0", (w_data.size() == 1) ? 32'(w_data[0]) : 32'hFFFFFFFF, 32'h10203);
        end

        // Randomized images with random stalls and ignored start pulses.
        for (int it = 0; it < 40; it++) begin
            int n;
            int sel;
            if (done || error) begin
                pulse_start();
            end else begin
                @(negedge clk); rst = 1;
                @(negedge clk); rst = 0;
            end
            img.delete();
            sel = int'($urandom_range(9));
            if (sel == 0) begin
                logic [7:0] hi;
                hi = 8'($urandom_range(1, 255));
                img.push_back(hi);
                img.push_back((hi == 8'h01) ? 8'($urandom_range(1, 255)) : 8'($urandom));
            end else begin
                n = int'($urandom_range(0, 5));
                img.push_back(8'h00);
                img.push_back(8'(n));
                for (int w = 0; w < n; w++) begin
                    img.push_back(($urandom_range(7) == 0) ? 8'($urandom_range(16, 255))
                                                          : 8'($urandom_range(0, 15)));
                    img.push_back(8'($urandom));
                    img.push_back(8'($urandom));
                end
                add_csum(img, $urandom_range(3) != 0);
            end
            send(img, -1, 0, 30);
            wait_end();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream writer for the 20-bit-wide instruction memory; it is the writer side of the port the CPU core only reads.
- Receives a length-prefixed program image over a valid/ready byte interface and packs each 3 bytes into one instruction word.
- Issues one write per instruction starting at address 0.
- Holds the CPU in reset (cpu_hold) until the image is fully loaded, then releases it.

Parameters:
- INST_W, 20, instruction word width; fixed layout {b0[3:0], b1, b2}.
- ADDR_W, 16, instruction memory address width; matches the pc width.
- IMEM_DEPTH, 256, number of instruction memory words; upper bound on program length.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that re-arms the loader from DONE or ERR; ignored in all other states.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at posedge clk.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  INST_W  write data.
- cpu_hold  out  1  high while loading; drives the CPU pc/reset hold.
- done  out  1  image loaded successfully; level signal.
- error  out  1  framing or length error; level signal.
- loaded_count  out  ADDR_W  number of words written so far.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - state = S_CNT_HI.
  - in_ready = 0 while rst is high; in_ready = 1 on the first cycle after rst deasserts.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_hold = 1, done = 0, error = 0, loaded_count = 0.
- States:
  - S_CNT_HI: accept byte into N[15:8].
  - S_CNT_LO: accept byte into N[7:0].
    - If N == 0: go to S_DONE.
    - If N > IMEM_DEPTH: go to S_ERR.
    - Otherwise: go to S_B0.
  - S_B0: accept b0.
    - If b0[7:4] != 0: go to S_ERR (framing error).
    - Otherwise: store b0[3:0] and go to S_B1.
  - S_B1: accept b1, go to S_B2.
  - S_B2: accept b2, go to S_WRITE.
  - S_WRITE: lasts exactly one cycle.
    - imem_we = 1, imem_addr = index, imem_wdata = {b0[3:0], b1, b2}; in_ready = 0.
    - Next cycle: index and loaded_count increment.
    - If index+1 == N: go to S_DONE (or S_CHK when the optional feature is compiled in).
    - Otherwise: go to S_B0.
  - S_DONE: done = 1, cpu_hold = 0, in_ready = 0. Stays here until start or rst.
  - S_ERR: error = 1, cpu_hold = 1, in_ready = 0. Stays here until start or rst.
- Handshake and latency:
  - in_ready = 1 in S_CNT_HI, S_CNT_LO, S_B0, S_B1 and S_B2.
  - Without backpressure, one word takes 4 cycles (3 accept + 1 write).
  - in_valid low stalls the loader with no state change; stalls may be of any length.
  - imem_we rises in the cycle after b2 is accepted.
- Release timing: cpu_hold falls and done rises in the same cycle, the cycle after the final imem_we.
- start:
  - In S_DONE or S_ERR: clears done, error, index and loaded_count; sets cpu_hold = 1; goes to S_CNT_HI.
  - In any other state: ignored.
- Index width: index never wraps, because N ≤ IMEM_DEPTH is checked first; imem_addr takes values 0..N-1 only.
- Reset mid-load: returns to the reset values. Words already written stay in memory; no clean-up writes are issued.
- in_data and in_valid are ignored when in_ready is 0.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last S_WRITE, go to S_CHK (in_ready = 1) and accept one byte.
  - If that byte equals the XOR of every b0/b1/b2 byte of the image: go to S_DONE.
  - Otherwise: go to S_ERR. loaded_count still equals N.
  - N == 0 also passes through S_CHK; the expected checksum is 0x00.
- Undefined: no S_CHK state and no trailing byte; behaviour is exactly as listed above.

Test Plan:
- Stream 00 02 | 01 23 45 | 0A BC DE with in_valid held high:
  - imem_we pulses at addr 0 with data 0x12345, then at addr 1 with data 0xABCDE.
  - done = 1, cpu_hold = 0 and loaded_count = 2 one cycle after the second write.
  - Total of 10 cycles from the first accept.
- Same stream with in_valid deasserted for 5 cycles between 23 and 45: same writes and data, completion delayed by exactly 5 cycles.
- Stream 00 03 | 1F 00 00: error = 1 after b0 is accepted, no imem_we, cpu_hold stays 1. Then pulse start and stream 00 00: done = 1 with no writes.
- Stream 01 01 (N = 257 > 256): error = 1 right after the second byte is accepted, no writes.
- Assert rst after 1.5 words are loaded: all outputs return to reset values, and a fresh image 00 01 | 00 00 07 loads addr 0 with data 0x00007.
- With PROGRAM_LOADER_CHECKSUM_EN: stream 00 01 | 01 02 03 | 00 gives done = 1 (checksum 0x00). Trailing byte 0x01 instead gives error = 1, with the word already written at addr 0.
